// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stack geometry and the stack controller state encoding.
package cpu_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned STK_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_POP_RD    = 2'd1,
        ST_POP_VALID = 2'd2
    } stk_state_t;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x DATA_W array, synchronous write, registered read, no reset.
module stack_ram #(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned DEPTH  = cpu_pkg::STK_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port and registered read port share the clock edge.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/stack_unit.sv
// Hardware stack for the CPU: edge-detected push/pop requests, two-stage pop
// read path, saturating occupancy count and sticky error flags.
module stack_unit #(
    parameter int unsigned  DATA_W    = cpu_pkg::DATA_W,
    parameter int unsigned  STK_DEPTH = cpu_pkg::STK_DEPTH,
    localparam int unsigned PTR_W     = $clog2(STK_DEPTH)
) (
    input  logic              clk,
    input  logic              init,
    input  logic              stk_push,
    input  logic              stk_pop,
    input  logic [DATA_W-1:0] stk_wdata,
    output logic [DATA_W-1:0] stk_rdata,
    output logic              stk_pop_valid,
    output logic              stk_full,
    output logic              stk_empty,
    output logic [PTR_W:0]    stk_count,
    output logic              stk_ovf,
    output logic              stk_unf,
    output logic              stk_coll
);

    import cpu_pkg::*;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(STK_DEPTH);

    stk_state_t        r_state;
    logic              r_push_q;
    logic              r_pop_q;
    logic [PTR_W:0]    r_count;
    logic [DATA_W-1:0] r_rdata;
    logic              r_valid;
    logic              r_ovf;
    logic              r_unf;
    logic              r_coll;

    logic              w_push_req;
    logic              w_pop_req;
    logic              w_full;
    logic              w_empty;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [PTR_W-1:0]  w_wr_addr;
    logic [PTR_W-1:0]  w_rd_addr;
    logic [DATA_W-1:0] w_ram_rdata;

    // Request edge detection, occupancy decode and RAM port control.
    always_comb begin
        w_push_req = stk_push & ~r_push_q;
        w_pop_req  = stk_pop & ~r_pop_q;
        w_full     = (r_count == FULL_CNT);
        w_empty    = (r_count == '0);
        w_wr_addr  = r_count[PTR_W-1:0];
        // Low bits of count minus one still address the top entry when full.
        w_rd_addr  = r_count[PTR_W-1:0] - PTR_W'(1);
        w_ram_we   = (r_state == ST_IDLE) && w_push_req && !w_full;
        w_ram_re   = (r_state == ST_IDLE) && w_pop_req && !w_push_req && !w_empty;
    end

    // Stack controller FSM with registered outputs and sticky error flags.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_state  <= ST_IDLE;
            r_push_q <= 1'b0;
            r_pop_q  <= 1'b0;
            r_count  <= '0;
            r_rdata  <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_coll   <= 1'b0;
        end else begin
            r_push_q <= stk_push;
            r_pop_q  <= stk_pop;
            case (r_state)
                ST_IDLE: begin
                    if (w_push_req) begin
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_count <= r_count + (PTR_W + 1)'(1);
                        end
                        if (w_pop_req) begin
                            r_coll <= 1'b1;
                        end
                    end else if (w_pop_req) begin
                        if (w_empty) begin
                            r_unf <= 1'b1;
                        end else begin
                            r_count <= r_count - (PTR_W + 1)'(1);
                            r_state <= ST_POP_RD;
                        end
                    end
                end
                ST_POP_RD: begin
                    if (w_push_req) begin
                        r_coll <= 1'b1;
                    end
                    r_rdata <= w_ram_rdata;
                    r_valid <= 1'b1;
                    r_state <= ST_POP_VALID;
                end
                ST_POP_VALID: begin
                    if (w_push_req) begin
                        r_coll <= 1'b1;
                    end
                    if (!stk_pop) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (STK_DEPTH),
        .ADDR_W (PTR_W)
    ) u_stack_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_wr_addr),
        .i_wdata (stk_wdata),
        .i_re    (w_ram_re),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_rdata)
    );

    assign stk_rdata     = r_rdata;
    assign stk_pop_valid = r_valid;
    assign stk_full      = w_full;
    assign stk_empty     = w_empty;
    assign stk_count     = r_count;
    assign stk_ovf       = r_ovf;
    assign stk_unf       = r_unf;
    assign stk_coll      = r_coll;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: a LIFO model feeds a scoreboard of
// expected popped words, checked when stk_pop_valid rises.
module tb_stack_unit;

    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          init = 1'b1;
    logic          stk_push = 1'b0;
    logic          stk_pop = 1'b0;
    logic [DW-1:0] stk_wdata = '0;
    logic [DW-1:0] stk_rdata;
    logic          stk_pop_valid;
    logic          stk_full;
    logic          stk_empty;
    logic [4:0]    stk_count;
    logic          stk_ovf;
    logic          stk_unf;
    logic          stk_coll;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] model[$];
    logic [DW-1:0] exp_q[$];
    logic          prev_valid = 1'b0;
    logic [DW-1:0] held_exp = '0;

    stack_unit #(
        .DATA_W    (DW),
        .STK_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .init          (init),
        .stk_push      (stk_push),
        .stk_pop       (stk_pop),
        .stk_wdata     (stk_wdata),
        .stk_rdata     (stk_rdata),
        .stk_pop_valid (stk_pop_valid),
        .stk_full      (stk_full),
        .stk_empty     (stk_empty),
        .stk_count     (stk_count),
        .stk_ovf       (stk_ovf),
        .stk_unf       (stk_unf),
        .stk_coll      (stk_coll)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare each new valid word, then its stability.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (stk_pop_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(stk_pop_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                held_exp = e;
                check("pop_rdata", 32'(stk_rdata), 32'(e));
            end
        end else if (stk_pop_valid && prev_valid) begin
            check("rdata_stable", 32'(stk_rdata), 32'(held_exp));
        end
        prev_valid = stk_pop_valid;
    end

    task automatic check_occ(input string tag);
        check({tag, "_count"}, 32'(stk_count), 32'(model.size()));
        check({tag, "_empty"}, 32'(stk_empty), 32'(model.size() == 0));
        check({tag, "_full"},  32'(stk_full),  32'(model.size() == DEPTH));
    endtask

    task automatic check_flags(input string tag, input logic ovf, input logic unf, input logic coll);
        check({tag, "_ovf"},  32'(stk_ovf),  32'(ovf));
        check({tag, "_unf"},  32'(stk_unf),  32'(unf));
        check({tag, "_coll"}, 32'(stk_coll), 32'(coll));
    endtask

    task automatic do_reset();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        init = 1'b1;
        stk_push = 1'b0;
        stk_pop = 1'b0;
        model.delete();
        #1;
        check("rst_valid", 32'(stk_pop_valid), 32'd0);
        check("rst_rdata", 32'(stk_rdata), 32'd0);
        check_occ("rst");
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic do_push(input logic [DW-1:0] v);
        @(negedge clk);
        stk_wdata = v;
        stk_push = 1'b1;
        if (model.size() < DEPTH) model.push_back(v);
        @(negedge clk);
        stk_push = 1'b0;
    endtask

    task automatic do_pop(input int hold);
        logic exp_valid;
        @(negedge clk);
        stk_pop = 1'b1;
        exp_valid = (model.size() > 0);
        if (exp_valid) exp_q.push_back(model.pop_back());
        @(negedge clk);
        check("pop_lat1_valid", 32'(stk_pop_valid), 32'd0);
        @(negedge clk);
        check("pop_lat2_valid", 32'(stk_pop_valid), 32'(exp_valid));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("pop_hold_valid", 32'(stk_pop_valid), 32'(exp_valid));
            check("pop_hold_count", 32'(stk_count), 32'(model.size()));
        end
        stk_pop = 1'b0;
        @(negedge clk);
        check("pop_release_valid", 32'(stk_pop_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset state.
        repeat (2) @(negedge clk);
        check_occ("por");
        check("por_valid", 32'(stk_pop_valid), 32'd0);
        check("por_rdata", 32'(stk_rdata), 32'd0);
        check_flags("por", 1'b0, 1'b0, 1'b0);
        init = 1'b0;

        // Pop on empty stack: underflow, no valid, rdata untouched.
        do_pop(1);
        check_flags("unf", 1'b0, 1'b1, 1'b0);
        check("unf_rdata", 32'(stk_rdata), 32'd0);
        check_occ("unf");

        // Two pushes, two pops in LIFO order.
        do_reset();
        do_push(16'h1234);
        do_push(16'hABCD);
        check_occ("push2");
        do_pop(0);
        check_occ("pop1");
        do_pop(2);
        check_occ("pop2");
        check_flags("lifo", 1'b0, 1'b0, 1'b0);

        // Push held high through reset release and 5 cycles: one write only.
        do_reset();
        @(negedge clk);
        init = 1'b1;
        stk_wdata = 16'h00FF;
        stk_push = 1'b1;
        @(negedge clk);
        init = 1'b0;
        model.push_back(16'h00FF);
        repeat (5) @(negedge clk);
        stk_push = 1'b0;
        @(negedge clk);
        check_occ("held_push");
        do_pop(0);
        check_occ("held_pop");

        // Fill, overflow, pop the top.
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_push(DW'(i));
        check_occ("fill");
        do_push(16'hDEAD);
        check_occ("ovf");
        check_flags("ovf", 1'b1, 1'b0, 1'b0);
        do_pop(3);
        check_occ("ovf_pop");
        check_flags("ovf_sticky", 1'b1, 1'b0, 1'b0);

        // Push while a pop is in flight is ignored and flags a collision.
        do_reset();
        do_push(16'h00A1);
        do_push(16'h00B2);
        @(negedge clk);
        stk_pop = 1'b1;
        exp_q.push_back(model.pop_back());
        repeat (2) @(negedge clk);
        stk_wdata = 16'h7777;
        stk_push = 1'b1;
        @(negedge clk);
        stk_push = 1'b0;
        check_occ("pv_push");
        check_flags("pv_push", 1'b0, 1'b0, 1'b1);
        check("pv_push_valid", 32'(stk_pop_valid), 32'd1);
        stk_pop = 1'b0;
        @(negedge clk);
        check("pv_release_valid", 32'(stk_pop_valid), 32'd0);
        do_pop(0);
        check_occ("pv_after");

        // Simultaneous push and pop with two entries: push wins, pop dropped.
        do_reset();
        do_push(16'h0011);
        do_push(16'h0022);
        @(negedge clk);
        stk_wdata = 16'h5555;
        stk_push = 1'b1;
        stk_pop = 1'b1;
        model.push_back(16'h5555);
        @(negedge clk);
        check_occ("coll");
        check_flags("coll", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("coll_no_valid", 32'(stk_pop_valid), 32'd0);
            check("coll_count", 32'(stk_count), 32'(model.size()));
        end
        stk_push = 1'b0;
        stk_pop = 1'b0;
        do_pop(0);
        check_occ("coll_pop");

        // Reset one cycle after a pop request aborts the pop.
        do_reset();
        do_push(16'h0101);
        do_push(16'h0202);
        do_push(16'h0303);
        check_occ("abort_pre");
        @(negedge clk);
        stk_pop = 1'b1;
        @(negedge clk);
        init = 1'b1;
        stk_pop = 1'b0;
        model.delete();
        #1;
        check("abort_valid", 32'(stk_pop_valid), 32'd0);
        check_occ("abort");
        check_flags("abort", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        init = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(stk_pop_valid), 32'd0);
        end
        check_occ("abort_post");

        check("sb_final", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter DATA_W, default 16, stack word width in bits.
REQ-002 Parameter STK_DEPTH, default 16, number of stack entries (power of two); PTR_W = log2(STK_DEPTH).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 init  input  1  reset, asynchronous, active-high.
REQ-005 stk_push  input  1  push request level from control unit; only its rising edge is a request.
REQ-006 stk_pop  input  1  pop request level from control unit; only its rising edge is a request.
REQ-007 stk_wdata  input  DATA_W  register-file operand to push.
REQ-008 stk_rdata  output  DATA_W  popped word, routed to register-file writeback (stwr=3).
REQ-009 stk_pop_valid  output  1  stk_rdata holds a valid popped word.
REQ-010 stk_full  output  1  count == STK_DEPTH.
REQ-011 stk_empty  output  1  count == 0.
REQ-012 stk_count  output  PTR_W+1  number of occupied entries.
REQ-013 stk_ovf / stk_unf / stk_coll  output  1 each  sticky overflow / underflow / collision error flags.

Function
REQ-014 The block SHALL register stk_push and stk_pop each cycle and define push_req = stk_push & ~push_q and pop_req = stk_pop & ~pop_q.
REQ-015 The FSM SHALL have exactly three states: IDLE, POP_RD, POP_VALID.
REQ-016 In IDLE, push_req without pop_req and count < STK_DEPTH SHALL write stk_wdata to entry[count] and increment count at the same edge.
REQ-017 In IDLE, push_req with count == STK_DEPTH SHALL leave memory and count unchanged and set stk_ovf.
REQ-018 In IDLE, pop_req without push_req and count > 0 SHALL decrement count, issue a read of entry[count-1], and move to POP_RD.
REQ-019 In IDLE, pop_req with count == 0 SHALL set stk_unf, remain in IDLE, never assert stk_pop_valid, and leave stk_rdata unchanged.
REQ-020 Simultaneous push_req and pop_req SHALL perform the push per REQ-016/017, drop the pop, and set stk_coll.
REQ-021 POP_RD SHALL last exactly one cycle: it captures the read word into stk_rdata and moves to POP_VALID.
REQ-022 stk_pop_valid SHALL be 1 exactly while in POP_VALID; latency is 2 clocks from the edge that samples pop_req to the edge after which stk_pop_valid is high.
REQ-023 POP_VALID SHALL hold stk_pop_valid and stk_rdata stable while stk_pop = 1 and SHALL return to IDLE at the first edge that samples stk_pop = 0.
REQ-024 push_req in POP_RD or POP_VALID SHALL be ignored (no write, count unchanged) and SHALL set stk_coll.
REQ-025 stk_pop held high across multiple instructions SHALL NOT cause a second pop; a new pop requires stk_pop to go low, then high.
REQ-026 stk_full and stk_empty SHALL be combinational decodes of the registered count.
REQ-027 Write pointer SHALL NOT wrap: count saturates at STK_DEPTH (overflow) and at 0 (underflow).
REQ-028 Error flags SHALL be cleared only by init.

Reset
REQ-029 On init = 1, the block SHALL immediately set FSM = IDLE, count = 0, stk_rdata = 0, stk_pop_valid = 0, stk_ovf = stk_unf = stk_coll = 0, push_q = pop_q = 0.
REQ-030 init asserted in POP_RD or POP_VALID SHALL abort the pop with no valid pulse; memory contents are not cleared and are don't-care after reset.
REQ-031 After init deasserts, an input already high at the first edge SHALL count as a rising edge (since push_q/pop_q = 0).

Structure
REQ-032 DATA_W, STK_DEPTH, and the stack FSM state enum SHALL live in the shared CPU package cpu_pkg.
REQ-033 Storage SHALL be a sub-module stack_ram: STK_DEPTH x DATA_W, synchronous write, registered read, no reset.

Verification
REQ-034 Reset, push 0x1234, push 0xABCD, pop -> stk_rdata = 0xABCD with valid on the 2nd edge; pop again -> 0x1234, stk_empty = 1.
REQ-035 stk_push held high for 5 cycles with stk_wdata = 0x00FF -> stk_count = 1, only one write.
REQ-036 16 pushes of values 0..15 -> stk_full = 1; 17th push of 0xDEAD -> stk_ovf = 1, count = 16; pop -> 0x000F.
REQ-037 Pop on empty stack -> stk_unf = 1, stk_pop_valid stays 0, stk_rdata = 0 after reset.
REQ-038 push_req and pop_req on the same edge with count = 2 -> count = 3, stk_coll = 1, no valid.
REQ-039 init pulse one cycle after pop_req with count = 3 -> stk_pop_valid never rises, stk_count = 0, all flags 0.
